// File: rtl/pipreg_elastic.sv
// pipreg_elastic
//   Elastic pipeline register chain of DEPTH slots. Each slot carries a
//   control field and a data field with a valid bit. Entries move towards
//   the output one slot per cycle whenever the slot ahead frees up, so a
//   stalled output compacts the pipe before it starts refusing input.
//   Each slot can be killed independently. Data/ctrl registers only load
//   when a live entry moves in, so bubbles do not toggle the datapath.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset, clears all slots
//   in_valid   in   upstream entry present
//   in_ready   out  slot 0 can accept this cycle (combinational)
//   in_ctrl    in   control field of incoming entry
//   in_data    in   data field of incoming entry
//   kill       in   kill[i] cancels the entry in slot i (slot 0 = input side)
//   out_valid  out  output slot holds a live, unkilled entry
//   out_ready  in   downstream accepts this cycle
//   out_ctrl   out  output slot control, forced to 0 on a bubble
//   out_data   out  output slot data, never masked
//   occupancy  out  number of registered valid bits (ignores this cycle's kill)
module pipreg_elastic #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CTRL_W-1:0]            in_ctrl,
    input  logic [DATA_W-1:0]            in_data,
    input  logic [DEPTH-1:0]             kill,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CTRL_W-1:0]            out_ctrl,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  valid_q;
    logic [CTRL_W-1:0] ctrl_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic [DEPTH-1:0]  ev;      // valid after this cycle's kill
    logic [DEPTH:0]    ready;   // ready[i]: slot i may take a new entry
    logic [DEPTH-1:0]  src_v;   // effective valid of the entry behind slot i
    logic [CTRL_W-1:0] src_c [DEPTH];
    logic [DATA_W-1:0] src_d [DEPTH];

    // Ready propagates from the output back towards the input: a slot frees
    // up if it is empty (or killed) or its occupant moves forward this cycle.
    always_comb begin
        ev           = valid_q & ~kill;
        ready        = '0;
        ready[DEPTH] = out_ready;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            ready[DEPTH-1-j] = ~ev[DEPTH-1-j] | ready[DEPTH-j];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_src
        if (g == 0) begin : g_head
            assign src_v[g] = in_valid;
            assign src_c[g] = in_ctrl;
            assign src_d[g] = in_data;
        end else begin : g_body
            assign src_v[g] = ev[g-1];
            assign src_c[g] = ctrl_q[g-1];
            assign src_d[g] = data_q[g-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ctrl_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                // A slot that is not ready necessarily holds a live entry.
                valid_q[i] <= ready[i] ? src_v[i] : 1'b1;
                if (ready[i] && src_v[i]) begin
                    ctrl_q[i] <= src_c[i];
                    data_q[i] <= src_d[i];
                end
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(valid_q[i]);
        end
    end

    assign in_ready  = ready[0];
    assign out_valid = ev[DEPTH-1];
    assign out_ctrl  = ctrl_q[DEPTH-1] & {CTRL_W{out_valid}};
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: tb/tb_pipreg_elastic.sv
// tb_pipreg_elastic
//   Directed bench for pipreg_elastic (DEPTH=2). A slot-list model advances
//   live entries towards the output, compacting into freed positions, and a
//   per-cycle compare process checks every output against it. Hand-computed
//   literal checks and a literal list of expected emissions pin the model.
module tb_pipreg_elastic;

    localparam int D  = 2;
    localparam int DW = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic [D-1:0]  kill;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [$clog2(D+1)-1:0] occupancy;

    pipreg_elastic #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- model: positions 0..D-1, D-1 is the output ----------------
    logic          m_v [D];
    logic [CW-1:0] m_c [D];
    logic [DW-1:0] m_d [D];

    initial begin
        for (int i = 0; i < D; i++) begin
            m_v[i] = 1'b0; m_c[i] = '0; m_d[i] = '0;
        end
    end

    always @(posedge clk) begin
        logic          n_v [D];
        logic [CW-1:0] n_c [D];
        logic [DW-1:0] n_d [D];
        if (!rst_n) begin
            for (int i = 0; i < D; i++) begin
                m_v[i] = 1'b0; m_c[i] = '0; m_d[i] = '0;
            end
        end else begin
            for (int i = 0; i < D; i++) begin
                n_v[i] = 1'b0; n_c[i] = m_c[i]; n_d[i] = m_d[i];
            end
            // Walk surviving entries from the front; each steps forward if the
            // position ahead is free after the entries ahead of it have moved.
            for (int i = D - 1; i >= 0; i--) begin
                if (m_v[i] && !kill[i]) begin
                    if (i == D - 1) begin
                        if (!out_ready) n_v[i] = 1'b1;
                    end else if (!n_v[i+1]) begin
                        n_v[i+1] = 1'b1; n_c[i+1] = m_c[i]; n_d[i+1] = m_d[i];
                    end else begin
                        n_v[i] = 1'b1;
                    end
                end
            end
            if (in_valid && !n_v[0]) begin
                n_v[0] = 1'b1; n_c[0] = in_ctrl; n_d[0] = in_data;
            end
            for (int i = 0; i < D; i++) begin
                m_v[i] = n_v[i]; m_c[i] = n_c[i]; m_d[i] = n_d[i];
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [DW-1:0] dut_emit [$];

    always @(negedge clk) begin
        logic          e_ov;
        logic          e_ir;
        int            e_occ;
        if (chk_en) begin
            e_ov  = m_v[D-1] && !kill[D-1];
            e_ir  = out_ready;
            e_occ = 0;
            for (int i = 0; i < D; i++) begin
                if (!(m_v[i] && !kill[i])) e_ir = 1'b1;
                if (m_v[i]) e_occ++;
            end
            chk("cmp_out_valid", 64'(out_valid), 64'(e_ov));
            chk("cmp_out_ctrl",  64'(out_ctrl),  e_ov ? 64'(m_c[D-1]) : 64'd0);
            chk("cmp_out_data",  64'(out_data),  64'(m_d[D-1]));
            chk("cmp_in_ready",  64'(in_ready),  64'(e_ir));
            chk("cmp_occupancy", 64'(occupancy), 64'(e_occ));
            if (out_valid && out_ready) dut_emit.push_back(out_data);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input logic [D-1:0] k, input logic ordy);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        kill      = k;
        out_ready = ordy;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [DW-1:0] A  = 32'hA0A0_0001;
    localparam logic [DW-1:0] B  = 32'hB0B0_0002;
    localparam logic [DW-1:0] C  = 32'hC0C0_0003;
    localparam logic [DW-1:0] X  = 32'h1111_0004;
    localparam logic [DW-1:0] Y  = 32'h2222_0005;
    localparam logic [DW-1:0] P  = 32'h3333_0006;
    localparam logic [DW-1:0] Q  = 32'h4444_0007;
    localparam logic [DW-1:0] Z  = 32'h5555_0008;
    localparam logic [DW-1:0] R1 = 32'h6666_0009;
    localparam logic [DW-1:0] R2 = 32'h7777_000A;

    logic [DW-1:0] exp_emit [$];

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_ctrl = '0; in_data = '0; kill = '0; out_ready = 1'b1;
        step();
        chk_en = 1'b1;
        step();

        // reset state
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 32'h0, 2'b00, 1'b1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_ctrl",  64'(out_ctrl),  64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);

        // streaming 1..10, gap-free, two cycles latency
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, 8'(16 + k), 32'(k), 2'b00, 1'b1);
            step();
            exp_emit.push_back(32'(k));
            if (k >= 2) begin
                chk("stream_data",  64'(out_data),  64'(k - 1));
                chk("stream_ctrl",  64'(out_ctrl),  64'(16 + k - 1));
                chk("stream_occ",   64'(occupancy), 64'd2);
            end
        end
        drive(1'b0, 8'h00, 32'h0, 2'b00, 1'b1);
        step();
        chk("stream_last", 64'(out_data), 64'd10);
        chk("stream_tail_occ", 64'(occupancy), 64'd1);
        step();
        chk("stream_empty", 64'(out_valid), 64'd0);

        // backpressure
        drive(1'b1, 8'hA1, A, 2'b00, 1'b0); step();
        drive(1'b1, 8'hB2, B, 2'b00, 1'b0); step();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 8'hC3, C, 2'b00, 1'b0);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            step();
            chk("bp_data", 64'(out_data),  64'(A));
            chk("bp_ctrl", 64'(out_ctrl),  64'h A1);
            chk("bp_occ",  64'(occupancy), 64'd2);
        end
        drive(1'b0, 8'h00, 32'h0, 2'b00, 1'b1); step();
        chk("bp_release_b", 64'(out_data), 64'(B));
        step(); step();
        exp_emit.push_back(A);
        exp_emit.push_back(B);

        // full flush
        drive(1'b1, 8'h59, Y, 2'b00, 1'b0); step();
        drive(1'b1, 8'h58, X, 2'b00, 1'b0); step();
        drive(1'b0, 8'h00, 32'h0, 2'b11, 1'b1);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_out_ctrl",  64'(out_ctrl),  64'd0);
        chk("flush_in_ready",  64'(in_ready),  64'd1);
        step();
        drive(1'b0, 8'h00, 32'h0, 2'b00, 1'b1);
        chk("flush_occ",       64'(occupancy), 64'd0);
        chk("flush_valid_nxt", 64'(out_valid), 64'd0);
        chk("flush_data_hold", 64'(out_data),  64'(Y));
        step();

        // partial kill under stall
        drive(1'b1, 8'h50, P, 2'b00, 1'b0); step();
        drive(1'b1, 8'h51, Q, 2'b00, 1'b0); step();
        drive(1'b1, 8'h5A, Z, 2'b01, 1'b0);
        chk("pk_in_ready",  64'(in_ready),  64'd1);
        chk("pk_out_valid", 64'(out_valid), 64'd1);
        step();
        drive(1'b0, 8'h00, 32'h0, 2'b00, 1'b0);
        chk("pk_occ",  64'(occupancy), 64'd2);
        chk("pk_data", 64'(out_data),  64'(P));
        step();
        drive(1'b0, 8'h00, 32'h0, 2'b00, 1'b1); step();
        chk("pk_then_z", 64'(out_data), 64'(Z));
        chk("pk_z_ctrl", 64'(out_ctrl), 64'h5A);
        step(); step();
        exp_emit.push_back(P);
        exp_emit.push_back(Z);

        // power hold: toggling input data on bubbles must not load anything
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, (k % 2 == 0) ? 8'hFF : 8'h00,
                  (k % 2 == 0) ? 32'hFFFF_FFFF : 32'h0, 2'b00, 1'b1);
            step();
            chk("ph_out_data", 64'(out_data),       64'(Z));
            chk("ph_out_ctrl", 64'(out_ctrl),       64'd0);
            chk("ph_slot0",    64'(dut.data_q[0]),  64'(Z));
            chk("ph_slot1",    64'(dut.data_q[1]),  64'(Z));
        end

        // reset mid-stream
        drive(1'b1, 8'h61, R1, 2'b00, 1'b0); step();
        drive(1'b1, 8'h62, R2, 2'b00, 1'b0); step();
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 32'h0, 2'b00, 1'b0);
        step();
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 32'h0, 2'b00, 1'b1);
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_out_ctrl",  64'(out_ctrl),  64'd0);
        chk("mrst_out_data",  64'(out_data),  64'd0);
        chk("mrst_occupancy", 64'(occupancy), 64'd0);
        chk("mrst_in_ready",  64'(in_ready),  64'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("mrst_no_stale", 64'(out_valid), 64'd0);
        end

        // emitted stream: order, no loss, no duplication
        chk("emit_count", 64'(dut_emit.size()), 64'(exp_emit.size()));
        for (int i = 0; i < exp_emit.size(); i++) begin
            if (i < dut_emit.size())
                chk("emit_seq", 64'(dut_emit[i]), 64'(exp_emit[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
